// File: rtl/transposer_buf_pkg.sv
// Shared types and limits for the transposer buffer responder.
package transposer_buf_pkg;

  localparam int BUFFD_DEF  = 64;
  localparam int LINE_W_DEF = BUFFD_DEF * 8;
  localparam int RD_LAT_MAX = 8;

  typedef logic [LINE_W_DEF-1:0] line_t;

  typedef struct packed {
    logic  vld;
    line_t data;
  } rd_stage_t;

endpackage

// File: rtl/transposer_buf_resp_if.sv
// Buffer-side bus between the transposer (master) and the line buffer (slave).
// Optional perf counters appear when TRANSPOSER_BUF_PERF_CNT_EN is defined.
interface transposer_buf_resp_if #(
  parameter int AW    = 16,
  parameter int BUFFD = 64
);
  import transposer_buf_pkg::*;

  logic                 init_pulse;
  logic [AW-1:0]        raddr;
  logic                 raddr_vld;
  logic [BUFFD*8-1:0]   rdata;
  logic                 rdata_vld;
  logic [AW-1:0]        waddr;
  logic [BUFFD*8-1:0]   wdata;
  logic                 wdata_vld;
  logic [3:0]           rd_pending;
  logic                 err_oor;
`ifdef TRANSPOSER_BUF_PERF_CNT_EN
  logic [31:0]          rd_cnt;
  logic [31:0]          wr_cnt;
`endif

  modport master (
    output init_pulse, raddr, raddr_vld, waddr, wdata, wdata_vld,
    input  rdata, rdata_vld, rd_pending, err_oor
`ifdef TRANSPOSER_BUF_PERF_CNT_EN
    , input rd_cnt, wr_cnt
`endif
  );

  modport slave (
    input  init_pulse, raddr, raddr_vld, waddr, wdata, wdata_vld,
    output rdata, rdata_vld, rd_pending, err_oor
`ifdef TRANSPOSER_BUF_PERF_CNT_EN
    , output rd_cnt, wr_cnt
`endif
  );

endinterface

// File: rtl/transposer_buf_rdpipe.sv
// Fixed-latency read return pipe. Data in each stage only moves when the
// stage behind it is valid, so the last stage holds its line between returns.
// Only the valid bits are reset; data registers are left free-running.
module transposer_buf_rdpipe #(
  parameter int DATA_W = 512,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_vld_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_data_o
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t stg_q [RD_LAT];

  // Shift valid bits every cycle and advance data behind valid entries.
  always_ff @(posedge clk) begin
    if (in_vld_i) stg_q[0].data <= in_data_i;
    for (int i = 1; i < RD_LAT; i++) begin
      if (stg_q[i-1].vld) stg_q[i].data <= stg_q[i-1].data;
    end
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) stg_q[i].vld <= 1'b0;
    end else begin
      stg_q[0].vld <= in_vld_i;
      for (int i = 1; i < RD_LAT; i++) stg_q[i].vld <= stg_q[i-1].vld;
    end
  end

  assign out_vld_o  = stg_q[RD_LAT-1].vld;
  assign out_data_o = stg_q[RD_LAT-1].data;

endmodule

// File: rtl/transposer_buf_resp.sv
// Buffer-side responder: line array with write-first same-cycle bypass,
// fixed-latency read return, outstanding-read count and sticky range error.
// Optional saturating request counters under TRANSPOSER_BUF_PERF_CNT_EN.
module transposer_buf_resp
  import transposer_buf_pkg::*;
#(
  parameter int AW     = 16,
  parameter int BUFFD  = 64,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  transposer_buf_resp_if.slave   bus
);

  localparam int LINE_W = BUFFD * 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT    = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  // Extra top bit keeps DEPTH == 2**AW representable for the range compare.
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  logic [LINE_W-1:0] mem [DEPTH];

  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  ridx;
  logic [IDX_W-1:0]  widx;
  logic [LINE_W-1:0] rd_line_d;
  logic              pipe_vld;
  logic [LINE_W-1:0] pipe_data;
  logic              seen_q;
  logic              err_d, err_q;
  logic [3:0]        pend_d, pend_q;

  assign rd_in_range = {1'b0, bus.raddr} < DEPTH_A;
  assign wr_in_range = {1'b0, bus.waddr} < DEPTH_A;
  assign ridx        = bus.raddr[IDX_W-1:0];
  assign widx        = bus.waddr[IDX_W-1:0];

  // Line array write; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (bus.wdata_vld && wr_in_range) mem[widx] <= bus.wdata;
  end

  // Read snapshot: zero when out of range, write-first bypass on collision.
  always_comb begin
    rd_line_d = '0;
    if (rd_in_range) begin
      if (bus.wdata_vld && (bus.waddr == bus.raddr)) rd_line_d = bus.wdata;
      else                                           rd_line_d = mem[ridx];
    end
  end

  transposer_buf_rdpipe #(
    .DATA_W (LINE_W),
    .RD_LAT (LAT)
  ) u_rdpipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_vld_i   (bus.raddr_vld),
    .in_data_i  (rd_line_d),
    .out_vld_o  (pipe_vld),
    .out_data_o (pipe_data)
  );

  // Next-state for the sticky error flag and the outstanding-read count.
  always_comb begin
    err_d = err_q;
    if (bus.init_pulse) err_d = 1'b0;
    if ((bus.raddr_vld && !rd_in_range) || (bus.wdata_vld && !wr_in_range)) err_d = 1'b1;
    pend_d = pend_q + {3'b000, bus.raddr_vld} - {3'b000, pipe_vld};
  end

  // Control state; seen_q marks that the pipe tail holds a returned line,
  // so rdata reads as zero after reset until the first return.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q  <= 1'b0;
      pend_q <= 4'd0;
      seen_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      pend_q <= pend_d;
      if (pipe_vld) seen_q <= 1'b1;
    end
  end

  assign bus.rdata      = (pipe_vld || seen_q) ? pipe_data : '0;
  assign bus.rdata_vld  = pipe_vld;
  assign bus.rd_pending = pend_q;
  assign bus.err_oor    = err_q;

`ifdef TRANSPOSER_BUF_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Saturating counts of accepted in-range reads and writes.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.init_pulse) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      if (bus.raddr_vld && rd_in_range && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (bus.wdata_vld && wr_in_range && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_transposer_buf_resp.sv
// Directed bench for transposer_buf_resp (AW=16, BUFFD=64, DEPTH=1024, RD_LAT=2).
module tb_transposer_buf_resp;
  import transposer_buf_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  transposer_buf_resp_if #(.AW(16), .BUFFD(64)) bus ();

  transposer_buf_resp #(
    .AW(16), .BUFFD(64), .DEPTH(1024), .RD_LAT(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [15:0] ra;
    logic        wv;
    logic [15:0] wa;
    line_t       wd;
    logic        ini;
    logic        ev;
    line_t       ed;
    logic [3:0]  ep;
    logic        ee;
  } vec_t;

  vec_t  tbl [18];
  line_t dA, dB, dC, dD, dE, dF;

  function automatic vec_t mk(logic rv, logic [15:0] ra, logic wv, logic [15:0] wa,
                              line_t wd, logic ini, logic ev, line_t ed,
                              logic [3:0] ep, logic ee);
    vec_t v;
    v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd; v.ini = ini;
    v.ev = ev; v.ed = ed; v.ep = ep; v.ee = ee;
    return v;
  endfunction

  function automatic line_t sline(int i);
    return {16{32'h5100_0000 | 32'(i)}};
  endfunction

  task automatic chk(string name, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.raddr_vld  = 1'b0;
    bus.raddr      = '0;
    bus.wdata_vld  = 1'b0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.init_pulse = 1'b0;
  endtask

  initial begin
    int    nxt;
    int    peak;
    int    vcnt;
    line_t z;
    checks = 0;
    errors = 0;
    z  = '0;
    dA = {16{32'hAAAA_0005}};
    dB = {16{32'hBBBB_0007}};
    dC = {16{32'hCCCC_0009}};
    dD = {16{32'hDDDD_0009}};
    dE = {16{32'hEEEE_07D0}};
    dF = {16{32'hFFFF_03D0}};

    //          rv  ra     wv  wa     wd  ini  ev  ed  ep    ee
    tbl[0]  = mk(0, 0,     1, 5,     dA, 0,   0,  z,  4'd0, 0);
    tbl[1]  = mk(0, 0,     1, 9,     dC, 0,   0,  z,  4'd0, 0);
    tbl[2]  = mk(1, 5,     1, 976,   dF, 0,   0,  z,  4'd0, 0);
    tbl[3]  = mk(0, 0,     0, 0,     z,  0,   0,  z,  4'd1, 0);
    tbl[4]  = mk(1, 7,     1, 7,     dB, 0,   1,  dA, 4'd1, 0);
    tbl[5]  = mk(1, 9,     0, 0,     z,  0,   0,  dA, 4'd1, 0);
    tbl[6]  = mk(0, 0,     1, 9,     dD, 0,   1,  dB, 4'd2, 0);
    tbl[7]  = mk(1, 9,     0, 0,     z,  0,   1,  dC, 4'd1, 0);
    tbl[8]  = mk(1, 1024,  0, 0,     z,  0,   0,  dC, 4'd1, 0);
    tbl[9]  = mk(0, 0,     0, 0,     z,  0,   1,  dD, 4'd2, 1);
    tbl[10] = mk(0, 0,     0, 0,     z,  1,   1,  z,  4'd1, 1);
    tbl[11] = mk(0, 0,     1, 2000,  dE, 0,   0,  z,  4'd0, 0);
    tbl[12] = mk(0, 0,     1, 2000,  dE, 1,   0,  z,  4'd0, 1);
    tbl[13] = mk(0, 0,     0, 0,     z,  1,   0,  z,  4'd0, 1);
    tbl[14] = mk(1, 976,   0, 0,     z,  0,   0,  z,  4'd0, 0);
    tbl[15] = mk(0, 0,     0, 0,     z,  0,   0,  z,  4'd1, 0);
    tbl[16] = mk(0, 0,     0, 0,     z,  0,   1,  dF, 4'd1, 0);
    tbl[17] = mk(0, 0,     0, 0,     z,  0,   0,  dF, 4'd0, 0);

    // Reset state
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) step();
    chk("reset_rdata_vld", 512'(bus.rdata_vld), 512'(0));
    chk("reset_rdata", bus.rdata, z);
    chk("reset_rd_pending", 512'(bus.rd_pending), 512'(0));
    chk("reset_err_oor", 512'(bus.err_oor), 512'(0));
    reset_n = 1'b1;

    // Table: basic read, collision, snapshot, out-of-range, init_pulse
    for (int i = 0; i < 18; i++) begin
      bus.raddr_vld  = tbl[i].rv;
      bus.raddr      = tbl[i].ra;
      bus.wdata_vld  = tbl[i].wv;
      bus.waddr      = tbl[i].wa;
      bus.wdata      = tbl[i].wd;
      bus.init_pulse = tbl[i].ini;
      chk($sformatf("row%0d_rdata_vld", i), 512'(bus.rdata_vld), 512'(tbl[i].ev));
      chk($sformatf("row%0d_rdata", i), bus.rdata, tbl[i].ed);
      chk($sformatf("row%0d_rd_pending", i), 512'(bus.rd_pending), 512'(tbl[i].ep));
      chk($sformatf("row%0d_err_oor", i), 512'(bus.err_oor), 512'(tbl[i].ee));
      step();
    end
    idle_inputs();

    // Streaming: prefill lines 0..15 then read them back to back
    for (int i = 0; i < 16; i++) begin
      bus.wdata_vld = 1'b1;
      bus.waddr     = 16'(i);
      bus.wdata     = sline(i);
      step();
    end
    idle_inputs();
    nxt  = 0;
    peak = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus.raddr_vld = (cyc < 16);
      bus.raddr     = 16'(cyc);
      if (int'(bus.rd_pending) > peak) peak = int'(bus.rd_pending);
      if (bus.rdata_vld) begin
        chk($sformatf("stream_data%0d", nxt), bus.rdata, sline(nxt));
        chk($sformatf("stream_cycle%0d", nxt), 512'(cyc), 512'(nxt + 2));
        nxt++;
      end
      step();
    end
    idle_inputs();
    chk("stream_count", 512'(nxt), 512'(16));
    chk("stream_pending_peak", 512'(peak), 512'(2));
    chk("stream_pending_end", 512'(bus.rd_pending), 512'(0));

    // Reset with two reads in flight
    vcnt = 0;
    bus.raddr_vld = 1'b1;
    bus.raddr     = 16'd3;
    step();
    bus.raddr     = 16'd4;
    reset_n       = 1'b0;
    if (bus.rdata_vld) vcnt++;
    step();
    bus.raddr_vld = 1'b0;
    if (bus.rdata_vld) vcnt++;
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.rdata_vld) vcnt++;
      step();
    end
    chk("flush_no_vld", 512'(vcnt), 512'(0));
    chk("flush_pending", 512'(bus.rd_pending), 512'(0));
    chk("flush_rdata_zero", bus.rdata, z);

    // Array contents survive reset
    bus.raddr_vld = 1'b1;
    bus.raddr     = 16'd3;
    step();
    bus.raddr_vld = 1'b0;
    chk("post_reset_pending", 512'(bus.rd_pending), 512'(1));
    chk("post_reset_early_vld", 512'(bus.rdata_vld), 512'(0));
    step();
    chk("post_reset_vld", 512'(bus.rdata_vld), 512'(1));
    chk("post_reset_data", bus.rdata, sline(3));
    step();
    chk("post_reset_vld_drop", 512'(bus.rdata_vld), 512'(0));
    chk("post_reset_pending_end", 512'(bus.rd_pending), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transposer_buf_resp.md
Name: transposer_buf_resp

Overview:
- Buffer-side responder for the transposer's buffer interface.
- Accepts read requests (raddr/raddr_vld) and returns full lines (rdata/rdata_vld) after a fixed, parameterised latency.
- Accepts line writes (waddr/wdata/wdata_vld) into an internal line array.
- Sits between the transposer and the on-chip scratchpad. Also serves as the synthesizable buffer model in block-level simulation.

Parameters:
- AW, 16, address width in bits (matches the transposer).
- BUFFD, 64, line width in bytes; a line is BUFFD*8 bits.
- DEPTH, 1024, number of lines in the array; must satisfy DEPTH <= 2**AW.
- RD_LAT, 2, read latency in cycles from request to rdata_vld; legal range 1..8.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- init_pulse  in  1  one-cycle pulse that clears sticky error flags and counters.
- raddr  in  AW  read line address.
- raddr_vld  in  1  read request; one request per cycle, no backpressure.
- rdata  out  BUFFD*8  read line data.
- rdata_vld  out  1  rdata is valid this cycle.
- waddr  in  AW  write line address.
- wdata  in  BUFFD*8  write line data.
- wdata_vld  in  1  write request; one per cycle, no backpressure.
- rd_pending  out  4  number of accepted reads not yet returned.
- err_oor  out  1  sticky flag: an out-of-range read or write has occurred.

Behaviour:
- Reset values (reset_n low at a rising edge):
  - rdata=0, rdata_vld=0, rd_pending=0, err_oor=0.
  - All read-pipe valid bits are cleared; in-flight reads are discarded and never returned.
  - Array contents are NOT reset.
- Write path:
  - At an edge with wdata_vld=1 and waddr<DEPTH, mem[waddr]<=wdata.
  - If waddr>=DEPTH, the write is dropped and err_oor<=1.
- Read acceptance (cycle T, raddr_vld=1):
  - Stage-1 data = wdata if (wdata_vld && waddr==raddr && raddr<DEPTH); otherwise mem[raddr]. Same-cycle read and write to the same address is therefore write-first.
  - If raddr>=DEPTH, the data is all zeros and err_oor<=1.
  - Data is snapshotted at T. Writes in cycles T+1..T+RD_LAT-1 do not affect this read's return.
- Read pipe:
  - Shift register of depth RD_LAT carrying {vld, data}.
  - rdata_vld is asserted at T+RD_LAT, for exactly one cycle per request.
  - Back-to-back requests return back-to-back, in order.
  - For RD_LAT=1, rdata and rdata_vld are registered outputs of stage 1.
  - rdata holds its last value when rdata_vld=0; it is not zeroed.
- rd_pending:
  - Next value = rd_pending + raddr_vld − (returning read this cycle).
  - Maximum value is RD_LAT (<=8), so 4 bits never overflow.
- init_pulse:
  - Clears err_oor and the optional counters.
  - Does not flush the read pipe or alter the array.
  - If init_pulse and a new out-of-range event occur in the same cycle, the event wins and err_oor=1.
- Address arithmetic is unsigned. DEPTH is compared against the full AW-bit address, with no truncation or wrap.

Optional Feature:
- Macro: TRANSPOSER_BUF_PERF_CNT_EN.
- When defined:
  - Adds outputs rd_cnt[31:0] and wr_cnt[31:0].
  - Each counts accepted in-range requests.
  - Each saturates at 32'hFFFF_FFFF.
  - Both are cleared by reset_n or init_pulse.
  - Out-of-range requests are not counted.
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package transposer_buf_pkg:
  - line_t typedef (logic [BUFFD*8-1:0]).
  - RD_LAT_MAX=8 constant.
  - rd_stage_t struct {logic vld; line_t data}.
- Sub-module transposer_buf_rdpipe: parameterised RD_LAT shift register of rd_stage_t, with synchronous reset on the vld bits only.

Test Plan:
- Basic read: write mem[5]=A at cycle 0; read raddr=5 at cycle 2 with RD_LAT=2 -> rdata_vld=1 and rdata=A at cycle 4; rd_pending=1 during cycles 3–4, 0 at cycle 5.
- Write-first collision: same cycle wdata_vld=1, waddr=7, wdata=B and raddr_vld=1, raddr=7 -> returned data=B.
- Snapshot: read addr 9 (old C) at T, write addr 9=D at T+1 -> return at T+2 is C; a read at T+2 returns D.
- Streaming: 16 consecutive reads, addresses 0..15 -> 16 consecutive rdata_vld cycles, in order, with correct data; rd_pending peaks at 2.
- Out-of-range, DEPTH=1024:
  - Read raddr=1024 -> rdata=0 and err_oor=1.
  - Write waddr=2000 -> mem unchanged.
  - init_pulse -> err_oor=0.
- Reset mid-flight: issue 2 reads, assert reset_n=0 one cycle later -> no rdata_vld pulses appear; rd_pending=0; array contents retained (a read after reset returns the pre-reset data).
